fir_deconv: RTL and testbench
=============================

# fir_deconv

Inverse (deconvolution) stage for the team's fixed 4-tap FIR with coefficients {1,2,3,4}. It recovers the original 16-bit sample stream from the filter's 32-bit output stream by exact integer back-substitution: x[n] = y[n] − 2·x[n−1] − 3·x[n−2] − 4·x[n−3]. It sits at the receive end of a link that carries filtered samples, uses valid/ready handshakes on both sides, and flags any input that cannot have come from the forward filter.

## Interface
- `DW`, 16, recovered sample width (signed).
- `YW`, 32, filtered input width (signed).
- `clk`  in  1  rising-edge clock, single domain.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous pulse; zeroes history, returns to IDLE, clears `err`.
- `y_in`  in  YW  signed filtered sample.
- `in_valid`  in  1  `y_in` valid.
- `in_ready`  out  1  block accepts `y_in` this cycle.
- `x_out`  out  DW  signed recovered sample.
- `out_valid`  out  1  `x_out` valid.
- `out_ready`  in  1  downstream accepts `x_out`.
- `err`  out  1  sticky range fault.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- History registers h1, h2, h3 (DW each) hold x[n−1], x[n−2], x[n−3]. All are zero after reset and after `clear`.
- Accept: `in_valid && in_ready`.
- Computation is combinational on the accepted `y_in`:
  - s = y_in − 2·h1 − 3·h2 − 4·h3.
  - s is signed, YW+2 = 34 bits. Sign-extend every term before summing; overflow is impossible at this width.
- Range check: the result is in range iff −32768 ≤ s ≤ 32767, i.e. s fits in DW bits.
- On an in-range accept: `x_out` ← s[DW−1:0], `out_valid` ← 1, h3←h2, h2←h1, h1←s.
- FSM states:
  - IDLE (0): history zero, no sample processed yet.
  - RUN (1): normal operation.
  - FAULT (2): range error seen.
- Transitions:
  - IDLE→RUN on the first in-range accept.
  - IDLE/RUN→FAULT on an out-of-range accept.
  - FAULT→IDLE on `clear`.
  - Any state→IDLE on `clear`.
- Out-of-range accept: `err` ← 1 and the state goes to FAULT. Output and history follow Configuration.
- In FAULT:
  - `in_ready` = 1.
  - Accepted samples are discarded; no new `out_valid` is produced and history is frozen.
  - A pending output still drains normally.
- `clear` takes priority over a same-cycle accept; the accepted sample is dropped.

## Timing
- Reset values: `x_out`=0, `out_valid`=0, `err`=0, `state_o`=IDLE, `in_ready`=1.
- Latency: one cycle from accept to `out_valid`.
- Throughput: one sample per cycle while `out_ready` is high.
- `in_ready` = !`out_valid` || `out_ready`, outside FAULT.
- Output holding rule: while `out_valid && !out_ready`, `x_out` holds stable and `in_ready` is 0.
- Simultaneous drain and accept in the same cycle: the new sample replaces the old one, and `out_valid` stays 1.
- `clear` with output pending: `out_valid` is dropped in the next cycle.
- Reset asserted mid-stream: everything returns to reset values immediately (asynchronous). Any pending output is lost.

## Configuration
- `FIR_DECONV_SAT_EN` defined, on an out-of-range accept:
  - `x_out` is s saturated to +32767 or −32768, with `out_valid` pulsed.
  - The saturated value enters history.
  - The state still moves to FAULT.
- `FIR_DECONV_SAT_EN` not defined, on an out-of-range accept:
  - No output is produced.
  - History is not updated.
- `err` and FAULT behaviour are identical in both builds.

## Structure
- Shared package `fir_pkg`:
  - coefficient constants C0..C3 = 1,2,3,4 (C0 must be 1);
  - DW/YW defaults;
  - the FSM state enum (IDLE=0, RUN=1, FAULT=2).
- The forward filter imports the same package.
- One natural sub-module, `fir_deconv_core`: combinational back-substitution plus range check/saturate, returning s, `in_range` and the saturated value.
- Top level: FSM, history registers, handshake and output register.

## Test plan
- Impulse: y = 1,2,3,4,0,0 from reset, `out_ready`=1 → x_out = 1,0,0,0,0,0; state IDLE→RUN after the first sample.
- Step: y = 1,3,6,10,10 → x_out = 1,1,1,1,1.
- Mixed sign: y = −5,−10,−15,−20,0 → x_out = −5,0,0,0,0; values −32768 and +32767 recover exactly.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, `x_out` stable; after release, samples resume in order with no loss.
- Range fault: y = 40000 from reset → `err`=1, state FAULT.
  - With `FIR_DECONV_SAT_EN`: `x_out`=32767 with one valid pulse.
  - Without it: no valid.
  - Later samples produce nothing. `clear` → IDLE, `err`=0; y=7 → x_out=7.
- Reset mid-stream: assert `reset` with an output pending → `out_valid`=0 immediately. After release, y=1 → x_out=1 (history zero).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and FSM encoding for the team's 4-tap FIR {1,2,3,4} and its inverse.
package fir_pkg;

  localparam int unsigned FirDw = 16;
  localparam int unsigned FirYw = 32;

  // C0 must stay 1 so that back-substitution needs no division.
  localparam int C0 = 1;
  localparam int C1 = 2;
  localparam int C2 = 3;
  localparam int C3 = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFault = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_deconv_core.sv
// Combinational back-substitution x = y - C1*h1 - C2*h2 - C3*h3 with range check and saturation.
module fir_deconv_core
  import fir_pkg::*;
#(
  parameter int unsigned DW = FirDw,
  parameter int unsigned YW = FirYw
) (
  input  logic signed [YW-1:0]   y_i,
  input  logic signed [DW-1:0]   h1_i,
  input  logic signed [DW-1:0]   h2_i,
  input  logic signed [DW-1:0]   h3_i,
  output logic signed [YW+1:0]   s_o,
  output logic                   in_range_o,
  output logic signed [DW-1:0]   sat_o
);

  localparam int unsigned SW = YW + 2;
  localparam logic signed [SW-1:0] K1 = SW'(C1);
  localparam logic signed [SW-1:0] K2 = SW'(C2);
  localparam logic signed [SW-1:0] K3 = SW'(C3);

  logic signed [SW-1:0] y_ext, h1_ext, h2_ext, h3_ext;
  logic [SW-DW:0]       upper;

  assign y_ext  = SW'(y_i);
  assign h1_ext = SW'(h1_i);
  assign h2_ext = SW'(h2_i);
  assign h3_ext = SW'(h3_i);

  assign s_o = y_ext - K1 * h1_ext - K2 * h2_ext - K3 * h3_ext;

  // s fits in DW bits iff every bit from the DW sign position upward agrees.
  assign upper      = s_o[SW-1:DW-1];
  assign in_range_o = (&upper) || (~|upper);

  always_comb begin
    sat_o = s_o[DW-1:0];
    if (!in_range_o) begin
      sat_o = s_o[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_deconv.sv
// Deconvolution stage for the {1,2,3,4} FIR: FSM, history, valid/ready handshake, sticky error.
// Define FIR_DECONV_SAT_EN to emit a saturated sample (and keep it in history) on range faults.
module fir_deconv
  import fir_pkg::*;
#(
  parameter int unsigned DW = FirDw,
  parameter int unsigned YW = FirYw
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic signed [YW-1:0] y_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] x_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic [1:0]           state_o
);

  fir_state_e           state_q, state_d;
  logic signed [DW-1:0] h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic signed [DW-1:0] x_q, x_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;

  logic signed [YW+1:0] s_w;
  logic signed [DW-1:0] sat_w;
  logic                 in_range_w;
  logic                 accept;
  logic                 unused_s;

  fir_deconv_core #(
    .DW (DW),
    .YW (YW)
  ) u_core (
    .y_i        (y_in),
    .h1_i       (h1_q),
    .h2_i       (h2_q),
    .h3_i       (h3_q),
    .s_o        (s_w),
    .in_range_o (in_range_w),
    .sat_o      (sat_w)
  );

  assign unused_s = ^s_w[YW+1:DW];

`ifndef FIR_DECONV_SAT_EN
  logic unused_sat;
  assign unused_sat = ^sat_w;
`endif

  // FAULT swallows input so the link never stalls behind a bad stream.
  assign in_ready = (state_q == StFault) || !vld_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
    x_d     = x_q;
    vld_d   = vld_q;
    err_d   = err_q;

    if (vld_q && out_ready) begin
      vld_d = 1'b0;
    end

    if (clear) begin
      state_d = StIdle;
      h1_d    = '0;
      h2_d    = '0;
      h3_d    = '0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
    end else if (accept && state_q != StFault) begin
      if (in_range_w) begin
        x_d     = s_w[DW-1:0];
        vld_d   = 1'b1;
        h3_d    = h2_q;
        h2_d    = h1_q;
        h1_d    = s_w[DW-1:0];
        state_d = StRun;
      end else begin
        err_d   = 1'b1;
        state_d = StFault;
`ifdef FIR_DECONV_SAT_EN
        x_d     = sat_w;
        vld_d   = 1'b1;
        h3_d    = h2_q;
        h2_d    = h1_q;
        h1_d    = sat_w;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      x_q     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      x_q     <= x_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign x_out     = x_q;
  assign out_valid = vld_q;
  assign err       = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fir_deconv.sv
// Bench for fir_deconv: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_fir_deconv;

  localparam int unsigned DW = 16;
  localparam int unsigned YW = 32;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 clear = 1'b0;
  logic signed [YW-1:0] y_in = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] x_out;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 err;
  logic [1:0]           state_o;

  fir_deconv dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seen[$];
  int exp_q[$];

  // Reference model: recovered-sample history plus one pending output slot.
  int m_h1 = 0, m_h2 = 0, m_h3 = 0, m_x = 0, m_state = 0;
  bit m_pend = 1'b0, m_err = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : model
    longint s;
    bit     rdy;
    if (reset) begin
      m_h1 = 0; m_h2 = 0; m_h3 = 0; m_x = 0; m_state = 0;
      m_pend = 1'b0; m_err = 1'b0;
    end
    rdy = (m_state == 2) || !m_pend || out_ready;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, m_pend);
    chk("err", err, m_err);
    chk("state", state_o, m_state);
    if (m_pend) chk("x_out", x_out, m_x);
    if (!reset) begin
      if (out_valid && out_ready) seen.push_back(int'(x_out));
      if (m_pend && out_ready) m_pend = 1'b0;
      if (clear) begin
        m_h1 = 0; m_h2 = 0; m_h3 = 0; m_state = 0;
        m_pend = 1'b0; m_err = 1'b0;
      end else if (in_valid && rdy && m_state != 2) begin
        s = longint'(y_in) - 2 * m_h1 - 3 * m_h2 - 4 * m_h3;
        if (s >= -32768 && s <= 32767) begin
          m_x = int'(s); m_pend = 1'b1;
          m_h3 = m_h2; m_h2 = m_h1; m_h1 = m_x;
          m_state = 1;
        end else begin
          m_err = 1'b1; m_state = 2;
`ifdef FIR_DECONV_SAT_EN
          m_x = (s > 32767) ? 32767 : -32768;
          m_pend = 1'b1;
          m_h3 = m_h2; m_h2 = m_h1; m_h1 = m_x;
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int y);
    bit ok;
    in_valid = 1'b1;
    y_in     = y;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: y=%0d not accepted within 50 cycles", y);
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_seen(input string name, input int e[$]);
    chk({name, "_count"}, seen.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < seen.size()) chk(name, seen[i], e[i]);
    end
    seen.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    chk("rst_x_out", x_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state_o, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Impulse response of the forward filter.
    send(1);
    chk("idle_to_run", state_o, 1);
    send(2); send(3); send(4); send(0); send(0);
    tick(); tick(); tick();
    exp_q = '{1, 0, 0, 0, 0, 0};
    check_seen("impulse", exp_q);

    pulse_clear();
    send(1); send(3); send(6); send(10); send(10);
    tick(); tick(); tick();
    exp_q = '{1, 1, 1, 1, 1};
    check_seen("step", exp_q);

    pulse_clear();
    send(-5); send(-10); send(-15); send(-20); send(0);
    tick(); tick(); tick();
    exp_q = '{-5, 0, 0, 0, 0};
    check_seen("mixed", exp_q);

    pulse_clear();
    send(-32768);
    tick(); tick();
    pulse_clear();
    send(32767);
    tick(); tick();
    exp_q = '{-32768, 32767};
    check_seen("extremes", exp_q);

    // Backpressure: hold the output for 5 cycles with a sample waiting.
    pulse_clear();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    y_in      = 1;
    tick();
    y_in = 3;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_x", x_out, 1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    send(6); send(10);
    tick(); tick(); tick();
    exp_q = '{1, 1, 1, 1};
    check_seen("backpressure", exp_q);

    // Range fault from reset.
    do_reset();
    send(40000);
    chk("fault_err", err, 1);
    chk("fault_state", state_o, 2);
    send(5); send(9);
    tick(); tick(); tick();
    exp_q.delete();
`ifdef FIR_DECONV_SAT_EN
    exp_q.push_back(32767);
`endif
    check_seen("fault", exp_q);
    chk("fault_err_sticky", err, 1);
    pulse_clear();
    chk("clear_state", state_o, 0);
    chk("clear_err", err, 0);
    send(7);
    tick(); tick(); tick();
    exp_q = '{7};
    check_seen("after_clear", exp_q);

    // Asynchronous reset with an output pending.
    send(1); send(2);
    tick(); tick();
    seen.delete();
    out_ready = 1'b0;
    send(4);
    chk("pend_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_state", state_o, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    tick();
    send(1);
    tick(); tick(); tick();
    exp_q = '{1};
    check_seen("post_reset", exp_q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
